// File: rtl/rr_mux_arb.sv
// N-channel registered multiplexer whose select comes from an internal
// round-robin / fixed-priority arbiter, with a single backpressured output stage.
module rr_mux_arb #(
    parameter int unsigned  N_CH   = 4,
    parameter int unsigned  DATA_W = 8,
    localparam int unsigned CH_W   = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_ch,
    output logic [15:0]              busy_cnt
);

    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_any;
    logic              load_en;
    logic [DATA_W-1:0] sel_data;
    int unsigned       idx;

    assign load_en = !out_valid || out_ready;

    // Search order starts at ptr in round-robin mode, at 0 in fixed mode;
    // the wrap is a compare-and-subtract so non power-of-2 N_CH never aliases.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (mode) begin
                idx = i;
            end else begin
                idx = i + 32'(ptr);
                if (idx >= N_CH) idx = idx - N_CH;
            end
            if (!grant_any && in_valid[idx[CH_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (grant_idx == CH_W'(i)) sel_data = in_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && load_en && grant_any) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                in_ready[i] = (grant_idx == CH_W'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            busy_cnt  <= '0;
            ptr       <= '0;
        end else begin
            if (load_en) begin
                if (grant_any) begin
                    out_data  <= sel_data;
                    out_ch    <= grant_idx;
                    out_valid <= 1'b1;
                    ptr       <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (out_valid && !out_ready && busy_cnt != '1) begin
                busy_cnt <= busy_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Bench for rr_mux_arb: directed literal checks plus randomized traffic
// compared every cycle against a queue-free behavioural model (4- and 3-channel instances).
module tb_rr_mux_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [31:0] in_data4;
    logic [3:0]  in_valid4, in_ready4;
    logic [7:0]  out_data4;
    logic        out_valid4, out_ready4;
    logic [1:0]  out_ch4;
    logic [15:0] busy_cnt4;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic [7:0]  out_data3;
    logic        out_valid3, out_ready3;
    logic [1:0]  out_ch3;
    logic [15:0] busy_cnt3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_mux_arb #(.N_CH(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_ch(out_ch4), .busy_cnt(busy_cnt4)
    );

    rr_mux_arb #(.N_CH(3), .DATA_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_ch(out_ch3), .busy_cnt(busy_cnt3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_valid[2];
    int m_data[2];
    int m_ch[2];
    int m_ptr[2];
    int m_busy[2];

    function automatic int nch(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    function automatic logic [15:0] vld(input int i);
        return (i == 0) ? 16'(in_valid4) : 16'(in_valid3);
    endfunction

    function automatic logic ordy(input int i);
        return (i == 0) ? out_ready4 : out_ready3;
    endfunction

    function automatic int dat(input int i, input int k);
        return (i == 0) ? int'(in_data4[k*8 +: 8]) : int'(in_data3[k*8 +: 8]);
    endfunction

    // Winner is the valid channel at the smallest "distance": its index in
    // fixed mode, its rotational distance from the pointer in round-robin mode.
    function automatic int pick(input int n, input logic [15:0] v, input int p, input logic md);
        int best, bestd, d;
        best  = -1;
        bestd = n;
        for (int k = 0; k < n; k++) begin
            if (v[k]) begin
                d = md ? k : (k - p + n) % n;
                if (d < bestd) begin
                    bestd = d;
                    best  = k;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [15:0] exp_ready(input int i);
        int g;
        if (!rst_n) return 16'h0;
        if (m_valid[i] != 0 && !ordy(i)) return 16'h0;
        g = pick(nch(i), vld(i), m_ptr[i], mode);
        if (g < 0) return 16'h0;
        return 16'h1 << g;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_valid[i] = 0; m_data[i] = 0; m_ch[i] = 0; m_ptr[i] = 0; m_busy[i] = 0;
            end else begin
                int n, g;
                logic ld;
                n  = nch(i);
                ld = (m_valid[i] == 0) || ordy(i);
                if (m_valid[i] != 0 && !ordy(i) && m_busy[i] < 65535) m_busy[i]++;
                if (ld) begin
                    g = pick(n, vld(i), m_ptr[i], mode);
                    if (g >= 0) begin
                        m_data[i]  = dat(i, g);
                        m_ch[i]    = g;
                        m_valid[i] = 1;
                        m_ptr[i]   = (g + 1) % n;
                    end else begin
                        m_valid[i] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("ready4", 32'(in_ready4),  32'(exp_ready(0)));
        chk("valid4", 32'(out_valid4), m_valid[0]);
        chk("data4",  32'(out_data4),  m_data[0]);
        chk("ch4",    32'(out_ch4),    m_ch[0]);
        chk("busy4",  32'(busy_cnt4),  m_busy[0]);
        chk("ready3", 32'(in_ready3),  32'(exp_ready(1)));
        chk("valid3", 32'(out_valid3), m_valid[1]);
        chk("data3",  32'(out_data3),  m_data[1]);
        chk("ch3",    32'(out_ch3),    m_ch[1]);
        chk("busy3",  32'(busy_cnt3),  m_busy[1]);
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; mode = 1'b0;
        in_valid4 = 4'b1111; in_data4 = 32'h13121110; out_ready4 = 1'b1;
        in_valid3 = 3'b000;  in_data3 = 24'h0;        out_ready3 = 1'b1;
        #3;
        chk("rst_valid", 32'(out_valid4), 0);
        chk("rst_data",  32'(out_data4),  0);
        chk("rst_busy",  32'(busy_cnt4),  0);
        chk("rst_ready", 32'(in_ready4),  0);
        #4 rst_n = 1'b1;
        #1 chk("rr_first_ready", 32'(in_ready4), 32'h1);

        // round-robin fairness with all four held valid
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("rr_ch",    32'(out_ch4),    32'(k % 4));
            chk("rr_data",  32'(out_data4),  32'(8'h10 + k % 4));
            chk("rr_valid", 32'(out_valid4), 1);
        end

        // single channel, then pointer must sit at 3
        in_valid4 = 4'b0100; in_data4 = 32'h00330000;
        #1 chk("single_ready", 32'(in_ready4), 32'b0100);
        @(posedge clk); #1;
        chk("single_valid", 32'(out_valid4), 1);
        chk("single_data",  32'(out_data4),  32'h33);
        chk("single_ch",    32'(out_ch4),    2);
        in_valid4 = 4'b1111;
        #1 chk("ptr_after_ch2", 32'(in_ready4), 32'b1000);

        // fixed priority
        mode = 1'b1; in_valid4 = 4'b1010; in_data4 = 32'h44002200;
        repeat (3) begin
            @(posedge clk); #1;
            chk("fix_ch",   32'(out_ch4),   1);
            chk("fix_data", 32'(out_data4), 32'h22);
        end
        in_valid4 = 4'b1000;
        @(posedge clk); #1;
        chk("fix_ch3", 32'(out_ch4), 3);
        chk("fix_d3",  32'(out_data4), 32'h44);

        // backpressure
        out_ready4 = 1'b0; in_valid4 = 4'b0001; in_data4 = 32'h00000077;
        #1 chk("bp_ready0", 32'(in_ready4), 0);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_hold",  32'(out_data4), 32'h44);
            chk("bp_ready", 32'(in_ready4), 0);
        end
        chk("bp_busy5", 32'(busy_cnt4), 5);
        out_ready4 = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready4), 32'b0001);
        @(posedge clk); #1;
        chk("bp_valid", 32'(out_valid4), 1);
        chk("bp_data",  32'(out_data4),  32'h77);
        chk("bp_ch",    32'(out_ch4),    0);
        chk("bp_busy",  32'(busy_cnt4),  5);

        // 3-channel wrap
        mode = 1'b0; in_valid3 = 3'b100; in_data3 = 24'h550000;
        @(posedge clk); #1;
        chk("w3_ch2",  32'(out_ch3),   2);
        chk("w3_d2",   32'(out_data3), 32'h55);
        in_valid3 = 3'b111; in_data3 = 24'h665544;
        @(posedge clk); #1;
        chk("w3_ch0",  32'(out_ch3),   0);
        chk("w3_d0",   32'(out_data3), 32'h44);
        in_valid3 = 3'b000;

        // reset mid-stream
        in_valid4 = 4'b0001; in_data4 = 32'h0000005A;
        @(posedge clk); #1;
        chk("mr_data",  32'(out_data4),  32'h5A);
        chk("mr_valid", 32'(out_valid4), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid0", 32'(out_valid4), 0);
        chk("mr_data0",  32'(out_data4),  0);
        chk("mr_ch0",    32'(out_ch4),    0);
        chk("mr_busy0",  32'(busy_cnt4),  0);
        chk("mr_ready0", 32'(in_ready4),  0);
        @(posedge clk); #1;
        chk("mr_ready_hold", 32'(in_ready4), 0);
        #1 rst_n = 1'b1;
        #1 chk("mr_ready_back", 32'(in_ready4), 32'b0001);

        // randomized traffic
        repeat (3000) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            in_valid4  = 4'($urandom);
            in_data4   = $urandom;
            out_ready4 = ($urandom_range(0, 3) != 0);
            in_valid3  = 3'($urandom);
            in_data3   = 24'($urandom);
            out_ready3 = ($urandom_range(0, 3) != 0);
            rst_n      = ($urandom_range(0, 299) != 0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #7;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
